// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode-side signals of the prefetch stage.
// The slave modport is the fetch_queue view; the master modport is its environment.
interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;
    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       i_imem_rdata;
    logic              o_valid;
    logic [31:0]       o_instr;
    logic [ADDR_W-1:0] o_pc;
    logic              i_ready;
    logic [CNT_W-1:0]  o_count;

    modport slave (
        input  i_redirect, i_redirect_pc, i_imem_rdata, i_ready,
        output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_count
    );

    modport master (
        output i_redirect, i_redirect_pc, i_imem_rdata, i_ready,
        input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_count
    );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction prefetch feeding decode through a DEPTH-entry PC/instr FIFO.
// Fetches are credit-limited (buffered + in-flight <= DEPTH); redirects flush everything.
module fetch_queue #(
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          i_clk,
    input logic          i_rst,
    fetch_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0]       instr_q [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];

    logic              issue;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    credit_used;

    // Redirect target low bits are architecturally ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];

    always_comb begin
        credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
        issue       = !i_rst && !bus.i_redirect && (credit_used < (CNT_W + 1)'(DEPTH));
        // A response landing in a redirect cycle is dropped along with the flush.
        push        = inflight_q && !bus.i_redirect;
        pop         = (count_q != '0) && bus.i_ready && !bus.i_redirect;

        fetch_pc_d  = fetch_pc_q;
        tag_pc_d    = tag_pc_q;
        inflight_d  = issue;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (bus.i_redirect) begin
            fetch_pc_d = {bus.i_redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                tag_pc_d   = fetch_pc_q;
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_q <= RESET_PC;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            instr_q[wr_ptr_q] <= bus.i_imem_rdata;
            pc_q[wr_ptr_q]    <= tag_pc_q;
        end
    end

    assign bus.o_imem_req  = issue;
    assign bus.o_imem_addr = fetch_pc_q;
    assign bus.o_valid     = (count_q != '0);
    assign bus.o_instr     = instr_q[rd_ptr_q];
    assign bus.o_pc        = pc_q[rd_ptr_q];
    assign bus.o_count     = count_q;

    overflow_chk: assert property (@(posedge i_clk) disable iff (i_rst)
        !(push && !pop && count_q == CNT_W'(DEPTH)));
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random ready/redirect/reset traffic,
// checked by a scoreboard holding the architecturally expected PC/instruction stream.
module tb_fetch_queue;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();
    fetch_queue_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus2 ();

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus));
    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(bus2));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Synchronous instruction memory; garbage on cycles without a request.
    always @(posedge clk) begin
        bus.i_imem_rdata  <= bus.o_imem_req  ? mem_word(bus.o_imem_addr)  : $urandom;
        bus2.i_imem_rdata <= bus2.o_imem_req ? mem_word(bus2.o_imem_addr) : $urandom;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] sb_next;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural stream restarts at a word-aligned target after reset/redirect.
    task automatic sb_restart(input logic [31:0] target);
        sb.delete();
        sb_next = {target[31:2], 2'b00};
    endtask

    task automatic sb_topup();
        while (sb.size() < 32) begin
            sb.push_back({sb_next, mem_word(sb_next)});
            sb_next = sb_next + 32'd4;
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
        sb_topup();
    endtask

    // Monitor: pops the scoreboard on every accepted handshake.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    always @(negedge clk) begin
        if (rst) begin
            check("req_in_reset", bus.o_imem_req, 0);
            stall_prev = 1'b0;
        end else begin
            check("valid_vs_count", bus.o_valid, bus.o_count != 0);
            check("count_le_depth", bus.o_count <= DEPTH, 1);
            if (bus.i_redirect) check("req_in_redirect", bus.o_imem_req, 0);
            if (stall_prev) begin
                check("stall_pc_stable", bus.o_pc, prev_pc);
                check("stall_instr_stable", bus.o_instr, prev_instr);
            end
            if (bus.o_valid && bus.i_ready && !bus.i_redirect) begin
                n_pops++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pop_pc", bus.o_pc, e.pc);
                    check("pop_instr", bus.o_instr, e.instr);
                end
            end
            stall_prev = bus.o_valid && !bus.i_ready && !bus.i_redirect;
            prev_pc    = bus.o_pc;
            prev_instr = bus.o_instr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] wrap_exp [4];
    int          valid_cycles;
    bit          reached;

    initial begin
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        rst                = 1'b1;
        bus.i_redirect     = 1'b0;
        bus.i_redirect_pc  = '0;
        bus.i_ready        = 1'b1;
        bus2.i_redirect    = 1'b0;
        bus2.i_redirect_pc = '0;
        bus2.i_ready       = 1'b1;
        sb_restart(32'h0);
        repeat (3) drive_edge();
        check("rst_valid", bus.o_valid, 0);
        check("rst_count", bus.o_count, 0);
        check("rst_req", bus.o_imem_req, 0);

        // Startup and wrap-around of the second instance.
        rst = 1'b0;
        #1;
        check("start_req", bus.o_imem_req, 1);
        check("start_addr", bus.o_imem_addr, 32'h0);
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                check("wrap_req", bus2.o_imem_req, 1);
                check("wrap_addr", bus2.o_imem_addr, wrap_exp[c]);
            end
            if (c >= 2) begin
                check("wrap_valid", bus2.o_valid, 1);
                check("wrap_pc", bus2.o_pc, wrap_exp[c-2]);
            end
            if (c == 1) check("start_not_valid", bus.o_valid, 0);
            if (c == 2) check("first_valid", bus.o_valid, 1);
            drive_edge();
        end

        // Sustained throughput with ready held high.
        valid_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.o_valid) valid_cycles++;
            drive_edge();
        end
        check("throughput", valid_cycles, 20);

        // Backpressure.
        bus.i_ready = 1'b0;
        repeat (10) drive_edge();
        check("stall_count", bus.o_count, DEPTH);
        check("stall_req", bus.o_imem_req, 0);
        check("stall_head", bus.o_pc, sb[0].pc);
        bus.i_ready = 1'b1;
        repeat (10) drive_edge();

        // Redirect with three buffered entries and one fetch in flight.
        bus.i_ready = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 12 && !reached; c++) begin
            drive_edge();
            #1;
            if (bus.o_count == 3) reached = 1'b1;
        end
        check("wait_count3", reached, 1);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h200;
        sb_restart(32'h200);
        #1;
        check("redir_no_req", bus.o_imem_req, 0);
        drive_edge();
        bus.i_redirect = 1'b0;
        bus.i_ready    = 1'b1;
        #1;
        check("redir_flush_valid", bus.o_valid, 0);
        check("redir_flush_count", bus.o_count, 0);
        check("redir_req", bus.o_imem_req, 1);
        check("redir_addr", bus.o_imem_addr, 32'h200);
        repeat (8) drive_edge();

        // Redirect to an unaligned target while the head is being offered.
        check("pre_redir_valid", bus.o_valid, 1);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h303;
        sb_restart(32'h303);
        drive_edge();
        bus.i_redirect = 1'b0;
        #1;
        check("align_addr", bus.o_imem_addr, 32'h300);
        check("align_req", bus.o_imem_req, 1);
        check("align_count", bus.o_count, 0);
        repeat (8) drive_edge();

        // Back-to-back redirects: the later target wins.
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 32'h400;
        sb_restart(32'h400);
        drive_edge();
        bus.i_redirect_pc = 32'h500;
        sb_restart(32'h500);
        drive_edge();
        bus.i_redirect = 1'b0;
        #1;
        check("b2b_addr", bus.o_imem_addr, 32'h500);
        repeat (8) drive_edge();

        // Reset mid-stream with two buffered entries and a fetch in flight.
        bus.i_ready = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 12 && !reached; c++) begin
            drive_edge();
            #1;
            if (bus.o_count == 2) reached = 1'b1;
        end
        check("wait_count2", reached, 1);
        rst = 1'b1;
        sb_restart(32'h0);
        drive_edge();
        check("mid_rst_valid", bus.o_valid, 0);
        check("mid_rst_count", bus.o_count, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_req", bus.o_imem_req, 1);
        check("mid_rst_addr", bus.o_imem_addr, 32'h0);
        drive_edge();
        check("stale_not_pushed", bus.o_count, 0);
        bus.i_ready = 1'b1;
        repeat (10) drive_edge();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = int'($urandom % 100);
            bus.i_ready    = (($urandom % 10) < 7);
            bus.i_redirect = 1'b0;
            rst            = 1'b0;
            if (r < 3) begin
                bus.i_redirect    = 1'b1;
                bus.i_redirect_pc = $urandom;
                sb_restart(bus.i_redirect_pc);
            end else if (r == 3) begin
                rst = 1'b1;
                sb_restart(32'h0);
            end
            drive_edge();
        end
        rst            = 1'b0;
        bus.i_redirect = 1'b0;
        drive_edge();
        check("progress", n_pops > 500, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
